// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Single master of the storage_controller access port. It arbitrates the
//   core's instruction port (read-only) and data port (read/write with byte
//   enables) and turns each accepted request into the controller's level
//   protocol: memory_access is held until out_valid for reads and pulsed for
//   one cycle for writes. Addresses inside the external flash window are
//   rebased and flagged with external_storage_access. Writes to the flash
//   window are rejected, and a read that never completes is aborted after
//   TIMEOUT_CYCLES.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_*                       instruction req/gnt/rvalid port
//   data_*                        data req/gnt/rvalid port
//   memory_access .. mem_be,
//   external_storage_access       request side of storage_controller
//   d_out, out_valid              read completion from storage_controller
module mem_req_arbiter #(
  parameter logic [31:0] EXT_BASE       = 32'h8000_0000,
  parameter logic [31:0] EXT_SIZE       = 32'h0100_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        memory_access,
  output logic        memory_is_writing,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic [3:0]  mem_be,
  output logic        external_storage_access,
  input  logic [31:0] d_out,
  input  logic        out_valid
);

  localparam int          CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [31:0] EXT_MASK = ~(EXT_SIZE - 32'd1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e             state_q, state_d;
  logic               prefer_data_q, prefer_data_d;  // 1: data wins a tie
  logic               src_data_q, src_data_d;        // owner of the in-flight transaction
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_access_q, mem_access_d;
  logic               mem_wr_q, mem_wr_d;
  logic [31:0]        addr_q, addr_d;
  logic               ext_q, ext_d;
  logic [31:0]        d_in_q, d_in_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic               instr_rvalid_q, instr_rvalid_d;
  logic [31:0]        instr_rdata_q, instr_rdata_d;
  logic               instr_err_q, instr_err_d;
  logic               data_rvalid_q, data_rvalid_d;
  logic [31:0]        data_rdata_q, data_rdata_d;
  logic               data_err_q, data_err_d;

  logic               grant_data, grant_instr;
  logic [31:0]        sel_addr, sel_dn_addr;
  logic               sel_we, sel_ext;

  // Grant and decode of the request being accepted this cycle. The decoded
  // address is what gets latched, so the downstream port stays stable for the
  // whole access.
  always_comb begin
    grant_data  = (state_q == IDLE) && !rst && data_req_i &&
                  (!instr_req_i || prefer_data_q);
    grant_instr = (state_q == IDLE) && !rst && instr_req_i &&
                  (!data_req_i || !prefer_data_q);
    sel_addr    = grant_data ? data_addr_i : instr_addr_i;
    sel_we      = grant_data && data_we_i;
    sel_ext     = (sel_addr & EXT_MASK) == EXT_BASE;
    sel_dn_addr = (sel_ext ? (sel_addr - EXT_BASE) : sel_addr) & ~32'h3;
  end

  // Next-state logic. A response is described once via resp_* and routed to
  // the owning port after the case statement.
  logic        resp_fire, resp_to_data, resp_err;
  logic [31:0] resp_rdata;

  always_comb begin
    state_d        = state_q;
    prefer_data_d  = prefer_data_q;
    src_data_d     = src_data_q;
    cnt_d          = cnt_q;
    mem_access_d   = mem_access_q;
    mem_wr_d       = mem_wr_q;
    addr_d         = addr_q;
    ext_d          = ext_q;
    d_in_d         = d_in_q;
    mem_be_d       = mem_be_q;
    instr_rvalid_d = instr_rvalid_q;
    instr_rdata_d  = instr_rdata_q;
    instr_err_d    = instr_err_q;
    data_rvalid_d  = data_rvalid_q;
    data_rdata_d   = data_rdata_q;
    data_err_d     = data_err_q;
    resp_fire      = 1'b0;
    resp_to_data   = src_data_q;
    resp_err       = 1'b0;
    resp_rdata     = 32'h0;

    case (state_q)
      IDLE: begin
        if (grant_data || grant_instr) begin
          prefer_data_d = grant_instr;
          src_data_d    = grant_data;
          cnt_d         = '0;
          if (sel_we && sel_ext) begin
            // Flash is read-only: answer at once, never touch the controller.
            state_d      = RESP;
            resp_fire    = 1'b1;
            resp_to_data = 1'b1;
            resp_err     = 1'b1;
            resp_rdata   = ERR_RDATA;
          end else begin
            addr_d       = sel_dn_addr;
            ext_d        = sel_ext;
            mem_access_d = 1'b1;
            if (sel_we) begin
              state_d  = WR;
              mem_wr_d = 1'b1;
              d_in_d   = data_wdata_i;
              mem_be_d = data_be_i;
            end else begin
              state_d  = RD;
              mem_wr_d = 1'b0;
              mem_be_d = 4'hF;
            end
          end
        end
      end
      RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Valid data takes priority over a timeout landing on the same cycle.
        if (out_valid) begin
          resp_fire  = 1'b1;
          resp_rdata = d_out;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
          resp_rdata = ERR_RDATA;
        end
        if (resp_fire) begin
          state_d      = RESP;
          mem_access_d = 1'b0;
          mem_be_d     = 4'h0;
        end
      end
      WR: begin
        state_d      = RESP;
        mem_access_d = 1'b0;
        mem_wr_d     = 1'b0;
        d_in_d       = 32'h0;
        mem_be_d     = 4'h0;
        resp_fire    = 1'b1;
      end
      RESP: begin
        state_d        = IDLE;
        instr_rvalid_d = 1'b0;
        instr_rdata_d  = 32'h0;
        instr_err_d    = 1'b0;
        data_rvalid_d  = 1'b0;
        data_rdata_d   = 32'h0;
        data_err_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (resp_fire) begin
      if (resp_to_data) begin
        data_rvalid_d = 1'b1;
        data_rdata_d  = resp_rdata;
        data_err_d    = resp_err;
      end else begin
        instr_rvalid_d = 1'b1;
        instr_rdata_d  = resp_rdata;
        instr_err_d    = resp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      prefer_data_q  <= 1'b1;
      src_data_q     <= 1'b0;
      cnt_q          <= '0;
      mem_access_q   <= 1'b0;
      mem_wr_q       <= 1'b0;
      addr_q         <= 32'h0;
      ext_q          <= 1'b0;
      d_in_q         <= 32'h0;
      mem_be_q       <= 4'h0;
      instr_rvalid_q <= 1'b0;
      instr_rdata_q  <= 32'h0;
      instr_err_q    <= 1'b0;
      data_rvalid_q  <= 1'b0;
      data_rdata_q   <= 32'h0;
      data_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prefer_data_q  <= prefer_data_d;
      src_data_q     <= src_data_d;
      cnt_q          <= cnt_d;
      mem_access_q   <= mem_access_d;
      mem_wr_q       <= mem_wr_d;
      addr_q         <= addr_d;
      ext_q          <= ext_d;
      d_in_q         <= d_in_d;
      mem_be_q       <= mem_be_d;
      instr_rvalid_q <= instr_rvalid_d;
      instr_rdata_q  <= instr_rdata_d;
      instr_err_q    <= instr_err_d;
      data_rvalid_q  <= data_rvalid_d;
      data_rdata_q   <= data_rdata_d;
      data_err_q     <= data_err_d;
    end
  end

  assign instr_gnt_o             = grant_instr;
  assign data_gnt_o              = grant_data;
  assign instr_rvalid_o          = instr_rvalid_q;
  assign instr_rdata_o           = instr_rdata_q;
  assign instr_err_o             = instr_err_q;
  assign data_rvalid_o           = data_rvalid_q;
  assign data_rdata_o            = data_rdata_q;
  assign data_err_o              = data_err_q;
  assign memory_access           = mem_access_q;
  assign memory_is_writing       = mem_wr_q;
  assign addr                    = addr_q;
  assign external_storage_access = ext_q;
  assign d_in                    = d_in_q;
  assign mem_be                  = mem_be_q;

endmodule
